// File: rtl/bcd_pkg.sv
// Shared constants, FSM encoding and add-3 helper for the BCD converter.
package bcd_pkg;

    localparam int unsigned BCD_DIGIT_W = 4;
    localparam logic [BCD_DIGIT_W-1:0] ADD3_THRESH = 4'd5;
    localparam logic [BCD_DIGIT_W-1:0] ADD3_VALUE  = 4'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_e;

    // Double-dabble correction: digits of 5 or more get 3 added before the shift.
    function automatic logic [BCD_DIGIT_W-1:0] add3(input logic [BCD_DIGIT_W-1:0] d);
        return (d >= ADD3_THRESH) ? BCD_DIGIT_W'(d + ADD3_VALUE) : d;
    endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit of the double-dabble datapath: add-3 correction, then a one-bit left shift.
module bcd_digit_cell
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_i,
    input  logic                   shift_i,
    output logic [BCD_DIGIT_W-1:0] digit_c_o,
    output logic                   shift_c_o
);

    logic [BCD_DIGIT_W-1:0] adj;

    // Correct, then shift the lower bit in and the MSB out toward the next digit.
    always_comb begin
        adj       = add3(digit_i);
        digit_c_o = {adj[BCD_DIGIT_W-2:0], shift_i};
        shift_c_o = adj[BCD_DIGIT_W-1];
    end

endmodule

// File: rtl/bcd_converter.sv
// Sequential binary-to-BCD converter (one bit per cycle) with overflow saturation
// and a leading-zero significance mask.
module bcd_converter
    import bcd_pkg::*;
#(
    parameter int unsigned BIN_W  = 10,
    parameter int unsigned DIGITS = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [BIN_W-1:0]              in_bin,
    input  logic                          abort,
    output logic                          out_valid,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out,
    output logic                          ovf,
    output logic [DIGITS-1:0]             nz_mask,
    output logic                          busy
);

    localparam int unsigned BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic [BCD_W-1:0]   dig_q, dig_d;
    logic               acc_q, acc_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               ovf_q, ovf_d;
    logic [DIGITS-1:0]  nz_q, nz_d;
    logic               out_valid_q, out_valid_d;
    logic               in_ready_q, in_ready_d;
    logic               busy_q, busy_d;

    logic [BCD_DIGIT_W-1:0] cell_dig [DIGITS];
    logic                   cell_carry [DIGITS+1];
    logic [BCD_W-1:0]       conv_dig;
    logic [BCD_W-1:0]       sat_dig;
    logic [DIGITS-1:0]      nz_calc;

    assign cell_carry[0] = bin_q[BIN_W-1];

    // Digit cells chained LSB to MSB; the top carry feeds the overflow accumulator.
    for (genvar g = 0; g < int'(DIGITS); g++) begin : g_cell
        bcd_digit_cell u_cell (
            .digit_i   (dig_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .shift_i   (cell_carry[g]),
            .digit_c_o (cell_dig[g]),
            .shift_c_o (cell_carry[g+1])
        );
    end

    // Repack cell outputs and derive the saturated result and its significance mask.
    always_comb begin
        logic any_nz;
        conv_dig = '0;
        nz_calc  = '0;
        any_nz   = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            conv_dig[i*BCD_DIGIT_W +: BCD_DIGIT_W] = cell_dig[i];
        end
        sat_dig = acc_q ? {DIGITS{4'd9}} : dig_q;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            any_nz     = any_nz | (sat_dig[i*BCD_DIGIT_W +: BCD_DIGIT_W] != '0);
            nz_calc[i] = any_nz;
        end
        nz_calc[0] = 1'b1;
    end

    // Next-state and datapath update for IDLE / CONV / DONE.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bin_d       = bin_q;
        dig_d       = dig_q;
        acc_d       = acc_q;
        bcd_d       = bcd_q;
        ovf_d       = ovf_q;
        nz_d        = nz_q;
        out_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (!abort && in_valid) begin
                    bin_d   = in_bin;
                    dig_d   = '0;
                    acc_d   = 1'b0;
                    cnt_d   = CNT_W'(BIN_W);
                    state_d = CONV;
                end
            end
            CONV: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    bin_d = bin_q << 1;
                    dig_d = conv_dig;
                    acc_d = acc_q | cell_carry[DIGITS];
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                if (!abort) begin
                    out_valid_d = 1'b1;
                    ovf_d       = acc_q;
                    bcd_d       = sat_dig;
                    nz_d        = nz_calc;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d = (state_d == IDLE);
        busy_d     = (state_d != IDLE);
    end

    // State and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bin_q       <= '0;
            dig_q       <= '0;
            acc_q       <= 1'b0;
            bcd_q       <= '0;
            ovf_q       <= 1'b0;
            nz_q        <= DIGITS'(1);
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bin_q       <= bin_d;
            dig_q       <= dig_d;
            acc_q       <= acc_d;
            bcd_q       <= bcd_d;
            ovf_q       <= ovf_d;
            nz_q        <= nz_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign bcd_out   = bcd_q;
    assign ovf       = ovf_q;
    assign nz_mask   = nz_q;

endmodule

// File: tb/tb_bcd_converter.sv
// Bench for bcd_converter: a default instance (10-bit, 4 digits) and a 3-digit instance.
module tb_bcd_converter;

    logic       clk;
    logic       rst;
    logic       iv    [2];
    logic       abrt  [2];
    logic [9:0] bin   [2];
    logic       rdy   [2];
    logic       ov    [2];
    logic       ovf_o [2];
    logic       bsy   [2];
    logic [15:0] bcd0;
    logic [11:0] bcd1;
    logic [3:0]  nz0;
    logic [2:0]  nz1;

    int n_cmp = 0;
    int n_bad = 0;

    bcd_converter #(.BIN_W(10), .DIGITS(4)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(rdy[0]), .in_bin(bin[0]),
        .abort(abrt[0]), .out_valid(ov[0]), .bcd_out(bcd0), .ovf(ovf_o[0]),
        .nz_mask(nz0), .busy(bsy[0])
    );

    bcd_converter #(.BIN_W(10), .DIGITS(3)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(rdy[1]), .in_bin(bin[1]),
        .abort(abrt[1]), .out_valid(ov[1]), .bcd_out(bcd1), .ovf(ovf_o[1]),
        .nz_mask(nz1), .busy(bsy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          ndig [2] = '{4, 3};
    int          m_cnt [2];
    int          m_val [2];
    logic [39:0] e_bcd [2];
    logic [9:0]  e_nz  [2];
    logic        e_ovf [2];
    logic        e_ov  [2];
    logic        e_bsy [2];
    logic        e_rdy [2];
    bit          live = 0;

    // Decimal digits of v, saturated to all nines when v does not fit in nd digits.
    task automatic convert(input int v, input int nd, output logic [39:0] b,
                           output logic o, output logic [9:0] nz);
        int  r;
        bit  any;
        r = v;
        b = '0;
        for (int i = 0; i < nd; i++) begin
            b = b | (40'(r % 10) << (4 * i));
            r = r / 10;
        end
        o = (r != 0);
        if (o) begin
            b = '0;
            for (int i = 0; i < nd; i++) b = b | (40'(9) << (4 * i));
        end
        nz  = '0;
        any = 0;
        for (int i = nd - 1; i >= 0; i--) begin
            if (((b >> (4 * i)) & 40'hF) != 0) any = 1;
            nz[i] = any;
        end
        nz[0] = 1'b1;
    endtask

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            e_ov[d] = 1'b0;
            if (rst) begin
                m_cnt[d] = 0;
                e_bcd[d] = '0;
                e_ovf[d] = 1'b0;
                e_nz[d]  = 10'd1;
            end else if (m_cnt[d] > 0) begin
                if (abrt[d]) begin
                    m_cnt[d] = 0;
                end else begin
                    m_cnt[d]--;
                    if (m_cnt[d] == 0) begin
                        convert(m_val[d], ndig[d], e_bcd[d], e_ovf[d], e_nz[d]);
                        e_ov[d] = 1'b1;
                    end
                end
            end else if (!abrt[d] && iv[d]) begin
                m_val[d] = int'(bin[d]);
                m_cnt[d] = 10 + 1;
            end
            e_bsy[d] = (m_cnt[d] > 0);
            e_rdy[d] = (m_cnt[d] == 0);
        end
        if (rst) live = 1;
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (live) begin
            for (int d = 0; d < 2; d++) begin
                check($sformatf("m%0d_out_valid", d), 40'(ov[d]), 40'(e_ov[d]));
                check($sformatf("m%0d_in_ready", d), 40'(rdy[d]), 40'(e_rdy[d]));
                check($sformatf("m%0d_busy", d), 40'(bsy[d]), 40'(e_bsy[d]));
                check($sformatf("m%0d_ovf", d), 40'(ovf_o[d]), 40'(e_ovf[d]));
                check($sformatf("m%0d_bcd", d), (d == 0) ? 40'(bcd0) : 40'(bcd1), e_bcd[d]);
                check($sformatf("m%0d_nz", d), (d == 0) ? 40'(nz0) : 40'(nz1), 40'(e_nz[d]));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int d, input logic [9:0] v);
        iv[d]  = 1'b1;
        bin[d] = v;
        tick();
        iv[d]  = 1'b0;
    endtask

    task automatic wait_out(input int d, input string name, input int lat,
                            input logic [39:0] xb, input logic xo, input logic [9:0] xn);
        int n;
        bit got;
        n   = 0;
        got = 0;
        while (n < 40 && !got) begin
            tick();
            n++;
            got = ov[d];
        end
        check({name, "_latency"}, 40'(n), 40'(lat));
        check({name, "_bcd"}, (d == 0) ? 40'(bcd0) : 40'(bcd1), xb);
        check({name, "_ovf"}, 40'(ovf_o[d]), 40'(xo));
        check({name, "_nz"}, (d == 0) ? 40'(nz0) : 40'(nz1), 40'(xn));
    endtask

    initial begin
        int pulses;
        int k;
        int pc [3];
        logic [15:0] pb [3];
        logic [3:0]  pn [3];
        logic [9:0]  vals [3];

        vals = '{10'd7, 10'd42, 10'd305};
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            iv[d] = 1'b0; abrt[d] = 1'b0; bin[d] = '0;
        end
        repeat (3) tick();
        check("rst_bcd", 40'(bcd0), 40'h0);
        check("rst_nz", 40'(nz0), 40'h1);
        check("rst_ovf", 40'(ovf_o[0]), 40'h0);
        check("rst_busy", 40'(bsy[0]), 40'h0);
        check("rst_out_valid", 40'(ov[0]), 40'h0);
        rst = 1'b0;
        tick();
        check("rst_in_ready", 40'(rdy[0]), 40'h1);

        send(0, 10'd1023);
        wait_out(0, "v1023", 11, 40'h1023, 1'b0, 10'b1111);

        // Abort during the fifth CONV cycle of 512.
        send(0, 10'd512);
        repeat (4) tick();
        abrt[0] = 1'b1;
        tick();
        abrt[0] = 1'b0;
        check("abort_in_ready", 40'(rdy[0]), 40'h1);
        check("abort_busy", 40'(bsy[0]), 40'h0);
        check("abort_held_bcd", 40'(bcd0), 40'h1023);
        pulses = 0;
        repeat (15) begin
            tick();
            if (ov[0]) pulses++;
        end
        check("abort_no_pulse", 40'(pulses), 40'h0);

        // Abort wins over a simultaneous accept in IDLE.
        iv[0] = 1'b1; abrt[0] = 1'b1; bin[0] = 10'd77;
        tick();
        iv[0] = 1'b0; abrt[0] = 1'b0;
        check("abort_prio_busy", 40'(bsy[0]), 40'h0);

        send(0, 10'd0);
        wait_out(0, "v0", 11, 40'h0, 1'b0, 10'b0001);

        send(1, 10'd999);
        wait_out(1, "d3_999", 11, 40'h999, 1'b0, 10'b111);
        send(1, 10'd1000);
        wait_out(1, "d3_1000", 11, 40'h999, 1'b1, 10'b111);

        // Back-to-back with in_valid held high.
        k = 0;
        pulses = 0;
        iv[0] = 1'b1;
        for (int c = 0; c < 60; c++) begin
            if (rdy[0]) begin
                if (k < 3) begin
                    bin[0] = vals[k];
                    k++;
                end else begin
                    iv[0] = 1'b0;
                end
            end
            tick();
            if (ov[0] && pulses < 3) begin
                pc[pulses] = c;
                pb[pulses] = bcd0;
                pn[pulses] = nz0;
                pulses++;
            end
        end
        iv[0] = 1'b0;
        check("b2b_pulses", 40'(pulses), 40'd3);
        if (pulses == 3) begin
            check("b2b_gap1", 40'(pc[1] - pc[0]), 40'd12);
            check("b2b_gap2", 40'(pc[2] - pc[1]), 40'd12);
            check("b2b_bcd0", 40'(pb[0]), 40'h0007);
            check("b2b_bcd1", 40'(pb[1]), 40'h0042);
            check("b2b_bcd2", 40'(pb[2]), 40'h0305);
            check("b2b_nz0", 40'(pn[0]), 40'b0001);
            check("b2b_nz1", 40'(pn[1]), 40'b0011);
            check("b2b_nz2", 40'(pn[2]), 40'b0111);
        end

        // Reset in the middle of a conversion.
        send(0, 10'd999);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_bcd", 40'(bcd0), 40'h0);
        check("midrst_nz", 40'(nz0), 40'h1);
        check("midrst_ovf", 40'(ovf_o[0]), 40'h0);
        check("midrst_busy", 40'(bsy[0]), 40'h0);
        pulses = 0;
        repeat (15) begin
            tick();
            if (ov[0]) pulses++;
        end
        check("midrst_no_pulse", 40'(pulses), 40'h0);
        check("midrst_ready", 40'(rdy[0]), 40'h1);

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bcd_converter.md
BCD_CONVERTER -- requirements
Module: bcd_converter

Interface
REQ-001 SHALL have parameter BIN_W, default 10: binary input width, legal range 1..32.
REQ-002 SHALL have parameter DIGITS, default 4: number of BCD output digits, legal range 1..10.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1: in_bin carries a value to convert.
REQ-006 SHALL have port in_ready, output, 1: block can accept a value.
REQ-007 SHALL have port in_bin, input, BIN_W: unsigned binary value.
REQ-008 SHALL have port abort, input, 1: cancels any conversion in progress.
REQ-009 SHALL have port out_valid, output, 1: one-cycle pulse, result registers updated.
REQ-010 SHALL have port bcd_out, output, 4*DIGITS: packed BCD, digit 0 in bits [3:0].
REQ-011 SHALL have port ovf, output, 1: value exceeded 10^DIGITS-1.
REQ-012 SHALL have port nz_mask, output, DIGITS: per-digit significance, for leading-zero blanking.
REQ-013 SHALL have port busy, output, 1: conversion in progress.

Function
REQ-014 SHALL implement an FSM with states IDLE, CONV and DONE.
REQ-015 SHALL drive in_ready high only in IDLE; a value is accepted on an edge where in_valid and in_ready are both high.
REQ-016 SHALL, on accept, load in_bin into a shift register, clear the digit registers and the ovf accumulator, load iteration count BIN_W, and enter CONV.
REQ-017 SHALL, on each CONV cycle, apply add-3 to every digit >= 5, then shift {digits, binary} left by one, all in one cycle (double-dabble), and decrement the count.
REQ-018 SHALL OR any bit shifted out of the MSB of the top digit into the ovf accumulator.
REQ-019 SHALL enter DONE after the BIN_W-th CONV cycle; DONE lasts one cycle, then the FSM returns to IDLE.
REQ-020 SHALL, in DONE, register bcd_out, ovf and nz_mask and pulse out_valid for exactly one cycle, BIN_W+1 cycles after the accepting edge.
REQ-021 SHALL saturate bcd_out to all digits 9 when ovf=1.
REQ-022 SHALL set nz_mask[i]=1 when any digit at index >= i is nonzero; nz_mask[0]=1 always.
REQ-023 SHALL hold bcd_out, ovf and nz_mask between out_valid pulses.
REQ-024 SHALL convert in_bin=0 normally (zero is not a stall condition).
REQ-025 SHALL drive busy high in CONV and DONE.
REQ-026 SHALL ignore in_valid while in_ready is low; no queuing.
REQ-027 SHALL, on abort in CONV or DONE, return to IDLE next edge with no out_valid and outputs unchanged.
REQ-028 SHALL give abort priority over accept in IDLE: no acceptance that cycle.
REQ-029 SHALL sustain a throughput of one conversion per BIN_W+2 cycles with in_valid held high.

Reset
REQ-030 SHALL, on rst, enter IDLE; out_valid=0, bcd_out=0, ovf=0, nz_mask=1 (bit 0 only), busy=0; in_ready high from the first cycle after rst deasserts.
REQ-031 SHALL, on rst mid-conversion, discard the conversion with no out_valid.

Structure
REQ-032 SHALL take the state encoding, BCD_DIGIT_W=4 and the add-3 threshold constant from shared package bcd_pkg.
REQ-033 SHALL instantiate sub-module bcd_digit_cell once per digit (add-3 correction plus one-bit shift-in/shift-out), chained by generate.

Verification
REQ-034 SHALL cover defaults, accept in_bin=1023: out_valid 11 cycles after accept, bcd_out=0x1023, ovf=0, nz_mask=4'b1111.
REQ-035 SHALL cover defaults, in_bin=0: bcd_out=0x0000, nz_mask=4'b0001, ovf=0, out_valid still pulses.
REQ-036 SHALL cover DIGITS=3, BIN_W=10: in_bin=999 gives 0x999, ovf=0; in_bin=1000 gives 0x999, ovf=1.
REQ-037 SHALL cover abort at CONV cycle 5 of in_bin=512: no out_valid, previous outputs held, in_ready high the next cycle.
REQ-038 SHALL cover back-to-back in_valid with 7, 42, 305: three out_valid pulses 12 cycles apart, results 0x0007/0x0042/0x0305, nz_mask 0001/0011/0111.
REQ-039 SHALL cover rst asserted mid-conversion: no out_valid, all outputs at reset values.
